// File: rtl/uart_hex_reporter.sv
// uart_hex_reporter: buffers measurement values and reports each one to a byte-wide UART
// transmitter. A value is sent as uppercase ASCII hex, MSB nibble first, optionally followed
// by CR LF. Characters go out one at a time over the transmitter's start/data/busy handshake.
//
// Ports:
//   clk            system clock, shared with the transmitter
//   rst_n          asynchronous active-low reset
//   meas_valid_i   one-cycle strobe qualifying meas_value_i
//   meas_value_i   measurement to report
//   tx_busy_i      transmitter busy
//   tx_start_o     one-cycle start pulse to the transmitter
//   tx_data_o      ASCII character for the transmitter, stable until the next start
//   fifo_level_o   number of values waiting in the FIFO
//   drop_count_o   saturating count of values lost to a full FIFO
//   busy_o         high while a line is in progress or values are waiting
module uart_hex_reporter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SEND_CRLF  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        meas_valid_i,
  input  logic [DATA_WIDTH-1:0]       meas_value_i,
  input  logic                        tx_busy_i,
  output logic                        tx_start_o,
  output logic [7:0]                  tx_data_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [7:0]                  drop_count_o,
  output logic                        busy_o
);

  localparam int unsigned Digits = DATA_WIDTH / 4;
  localparam int unsigned NChars = Digits + ((SEND_CRLF != 0) ? 2 : 0);
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  // One spare code so the "past the digits" comparison never aliases.
  localparam int unsigned IdxW   = $clog2(NChars + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSend,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]        level_q, level_d;
  logic [7:0]            drop_q, drop_d;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [IdxW-1:0]       idx_q;
  logic                  tx_start_q;
  logic [7:0]            tx_data_q;

  logic                  push, pop, full, last_char;
  logic [DATA_WIDTH-1:0] head;
  logic [3:0]            nibble;
  logic [IdxW-1:0]       char_idx;
  logic [7:0]            cur_char;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign full = (level_q == (AddrW + 1)'(FIFO_DEPTH));
  assign pop  = (state_q == StLoad);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = meas_valid_i && (!full || pop);
  assign head = mem_q[rd_ptr_q];

  // In LOAD the first character is taken straight from the FIFO head.
  assign nibble    = pop ? head[DATA_WIDTH-1 -: 4] : shift_q[DATA_WIDTH-1 -: 4];
  assign char_idx  = pop ? '0 : idx_q;
  assign last_char = (idx_q == IdxW'(NChars - 1));

  always_comb begin
    cur_char = 8'h0A;
    if (char_idx < IdxW'(Digits)) begin
      cur_char = hex_char(nibble);
    end else if (char_idx == IdxW'(Digits)) begin
      cur_char = 8'h0D;
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (AddrW + 1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (AddrW + 1)'(1);
    end
    drop_d = drop_q;
    if (meas_valid_i && !push && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= meas_value_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Looking at push as well lets a strobe into an empty FIFO start the next cycle.
          if ((level_q != '0) || push) state_q <= StLoad;
        end
        StLoad: begin
          shift_q <= head;
          idx_q   <= '0;
          // Issue the first character directly when the transmitter is free, so it
          // goes out in the cycle after the load.
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= cur_char;
            state_q    <= StWaitBusy;
          end else begin
            state_q <= StSend;
          end
        end
        StSend: begin
          if (!tx_busy_i) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= cur_char;
            state_q    <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (tx_busy_i) state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (!tx_busy_i) begin
            if (last_char) begin
              idx_q   <= '0;
              state_q <= (level_q != '0) ? StLoad : StIdle;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              shift_q <= shift_q << 4;
              state_q <= StSend;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_start_o   = tx_start_q;
  assign tx_data_o    = tx_data_q;
  assign fifo_level_o = level_q;
  assign drop_count_o = drop_q;
  assign busy_o       = (state_q != StIdle) || (level_q != '0);

endmodule

// File: tb/tb_uart_hex_reporter.sv
// Testbench for uart_hex_reporter: two instances (with and without CR LF), each driving a
// behavioural transmitter that stays busy for a fixed number of cycles per character.
module tb_uart_hex_reporter;

  localparam int TxCycles = 10;
  localparam int Depth    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        meas_valid, mv2;
  logic [31:0] meas_value, val2;
  logic        tx_busy, tx_busy2, hold_busy;
  logic        tx_start, tx_start2;
  logic [7:0]  tx_data, tx_data2;
  logic [2:0]  fifo_level, lvl2;
  logic [7:0]  drop_count, drop2;
  logic        busy, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  // Transmitter models and protocol monitors.
  int         tx_cnt = 0, tx_cnt2 = 0;
  int         start_cnt = 0, start_cnt2 = 0;
  int         proto_err = 0;
  logic       prev_start = 1'b0, prev_start2 = 1'b0;
  logic [7:0] got_q[$], got2_q[$], exp_q[$];

  assign tx_busy  = (tx_cnt != 0) || hold_busy;
  assign tx_busy2 = (tx_cnt2 != 0);

  always #5 clk = ~clk;

  uart_hex_reporter #(.DATA_WIDTH(32), .FIFO_DEPTH(Depth), .SEND_CRLF(1)) dut (
    .clk(clk), .rst_n(rst_n), .meas_valid_i(meas_valid), .meas_value_i(meas_value),
    .tx_busy_i(tx_busy), .tx_start_o(tx_start), .tx_data_o(tx_data),
    .fifo_level_o(fifo_level), .drop_count_o(drop_count), .busy_o(busy)
  );

  uart_hex_reporter #(.DATA_WIDTH(32), .FIFO_DEPTH(Depth), .SEND_CRLF(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .meas_valid_i(mv2), .meas_value_i(val2),
    .tx_busy_i(tx_busy2), .tx_start_o(tx_start2), .tx_data_o(tx_data2),
    .fifo_level_o(lvl2), .drop_count_o(drop2), .busy_o(busy2)
  );

  always @(posedge clk) begin
    if (tx_start) begin
      if (tx_busy || prev_start) proto_err++;
      got_q.push_back(tx_data);
      start_cnt++;
      tx_cnt <= TxCycles;
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
    end
    prev_start <= tx_start;
  end

  always @(posedge clk) begin
    if (tx_start2) begin
      if (tx_busy2 || prev_start2) proto_err++;
      got2_q.push_back(tx_data2);
      start_cnt2++;
      tx_cnt2 <= TxCycles;
    end else if (tx_cnt2 != 0) begin
      tx_cnt2 <= tx_cnt2 - 1;
    end
    prev_start2 <= tx_start2;
  end

  // Reference: one line = 8 uppercase hex digits from the MSB, then optional CR LF.
  function automatic void expect_line(input logic [31:0] v, input bit crlf);
    string hexs = "0123456789ABCDEF";
    for (int i = 7; i >= 0; i--) begin
      int k = int'((v >> (4 * i)) & 32'hF);
      exp_q.push_back(hexs[k]);
    end
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic wait_idle(input bit second, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!second && !busy && (tx_cnt == 0) && !hold_busy) begin ok = 1'b1; break; end
      if (second && !busy2 && (tx_cnt2 == 0)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; meas_valid = 1'b0; meas_value = '0; mv2 = 1'b0; val2 = '0;
    hold_busy = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    n_checks++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++;
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_checks++;
    if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    bit ok; int bad;
    got_q.delete(); exp_q.delete(); start_cnt = 0;
    expect_line(32'h1234ABCD, 1'b1);
    meas_valid = 1'b1; meas_value = 32'h1234ABCD;       // cycle 0
    @(negedge clk); meas_valid = 1'b0;                  // cycle 1: LOAD
    n_checks++;
    if (tx_start !== 1'b0) begin n_fail++; $display("FAIL single_c1_start: got %b want 0", tx_start); end
    @(negedge clk);                                     // cycle 2: first pulse
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== exp_q[0]) begin
      n_fail++; $display("FAIL single_latency: start %b data %h want 1 %h", tx_start, tx_data, exp_q[0]);
    end
    wait_idle(1'b0, 1000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: busy %b want 0", busy); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad = i; break; end
    n_checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_bytes: %0d bytes, first diff at %0d, want %0d bytes",
                         got_q.size(), bad, exp_q.size());
    end
    n_checks++;
    if (start_cnt != 10) begin n_fail++; $display("FAIL single_pulses: got %0d want 10", start_cnt); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_burst;
    bit ok; int bad;
    logic [31:0] vals [6];
    got_q.delete(); exp_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vals[i] = $urandom;
      // One value goes into the line being formed, Depth more wait in the FIFO.
      if (i < 1 + Depth) expect_line(vals[i], 1'b1);
      meas_valid = 1'b1; meas_value = vals[i];
      @(negedge clk);
    end
    meas_valid = 1'b0;
    n_checks++;
    if (drop_count !== 8'd1) begin n_fail++; $display("FAIL burst_drop: got %0d want 1", drop_count); end
    n_checks++;
    if (fifo_level !== 3'(Depth)) begin n_fail++; $display("FAIL burst_level: got %0d want %0d", fifo_level, Depth); end
    hold_busy = 1'b0;
    wait_idle(1'b0, 3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL burst_timeout: busy %b want 0", busy); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad = i; break; end
    n_checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL burst_bytes: %0d bytes, first diff at %0d, want %0d bytes",
                         got_q.size(), bad, exp_q.size());
    end
    n_checks++;
    if (proto_err != 0) begin n_fail++; $display("FAIL burst_protocol: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_no_crlf;
    bit ok; int bad;
    logic [31:0] v [2];
    v[0] = 32'h0000000F; v[1] = $urandom;
    got2_q.delete(); exp_q.delete(); start_cnt2 = 0;
    for (int n = 0; n < 2; n++) begin
      expect_line(v[n], 1'b0);
      mv2 = 1'b1; val2 = v[n];
      @(negedge clk); mv2 = 1'b0;
      wait_idle(1'b1, 1000, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL nocrlf_timeout: busy %b want 0", busy2); end
    end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got2_q.size() || got2_q[i] !== exp_q[i]) begin bad = i; break; end
    n_checks++;
    if (bad >= 0 || got2_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL nocrlf_bytes: %0d bytes, first diff at %0d, want %0d bytes",
                         got2_q.size(), bad, exp_q.size());
    end
    n_checks++;
    if (start_cnt2 != 16) begin n_fail++; $display("FAIL nocrlf_pulses: got %0d want 16", start_cnt2); end
  endtask

  task automatic test_busy_hold;
    bit ok; int bad; int seen = 0;
    logic [31:0] v;
    v = $urandom;
    got_q.delete(); exp_q.delete();
    expect_line(v, 1'b1);
    hold_busy = 1'b1;
    meas_valid = 1'b1; meas_value = v;
    @(negedge clk); meas_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx_start) seen++;
      @(negedge clk);
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL hold_no_start: got %0d pulses want 0", seen); end
    hold_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== exp_q[0]) begin
      n_fail++; $display("FAIL hold_release: start %b data %h want 1 %h", tx_start, tx_data, exp_q[0]);
    end
    wait_idle(1'b0, 1000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL hold_timeout: busy %b want 0", busy); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad = i; break; end
    n_checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL hold_bytes: %0d bytes, first diff at %0d, want %0d bytes",
                         got_q.size(), bad, exp_q.size());
    end
  endtask

  task automatic test_reset_midline;
    bit ok; int bad; int cyc = 0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      meas_valid = 1'b1; meas_value = $urandom;
      @(negedge clk);
    end
    meas_valid = 1'b0;
    while (got_q.size() < 3 && cyc < 300) begin @(negedge clk); cyc++; end
    n_checks++;
    if (got_q.size() < 3) begin n_fail++; $display("FAIL midline_progress: got %0d chars want 3", got_q.size()); end
    n_checks++;
    if (fifo_level !== 3'd2 || drop_count !== 8'd1) begin
      n_fail++; $display("FAIL midline_pre: level %0d drop %0d want 2 1", fifo_level, drop_count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_start !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 8'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midline_reset: start %b level %0d drop %0d busy %b want 0 0 0 0",
                         tx_start, fifo_level, drop_count, busy);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    expect_line(32'hFFFFFFFF, 1'b1);
    meas_valid = 1'b1; meas_value = 32'hFFFFFFFF;
    @(negedge clk); meas_valid = 1'b0;
    wait_idle(1'b0, 1000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL midline_timeout: busy %b want 0", busy); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad = i; break; end
    n_checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midline_bytes: %0d bytes, first diff at %0d, want %0d bytes",
                         got_q.size(), bad, exp_q.size());
    end
  endtask

  task automatic test_saturate;
    bit ok; int bad; int drop_bad = -1; int exp_drop;
    logic [7:0] drop_at_bad = 8'h00;
    logic [31:0] v;
    got_q.delete(); exp_q.delete();
    hold_busy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      // Strobes beyond the 1 + Depth slots are dropped, capped at 255.
      exp_drop = (i > 1 + Depth) ? i - (1 + Depth) : 0;
      if (exp_drop > 255) exp_drop = 255;
      if (drop_bad < 0 && drop_count !== 8'(exp_drop)) begin drop_bad = i; drop_at_bad = drop_count; end
      v = $urandom;
      if (i < 1 + Depth) expect_line(v, 1'b1);
      meas_valid = 1'b1; meas_value = v;
      @(negedge clk);
    end
    meas_valid = 1'b0;
    n_checks++;
    if (drop_bad >= 0) begin
      n_fail++; $display("FAIL sat_track: at strobe %0d drop %0d differs from model", drop_bad, drop_at_bad);
    end
    n_checks++;
    if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_final: got %0d want 255", drop_count); end
    n_checks++;
    if (fifo_level !== 3'(Depth)) begin n_fail++; $display("FAIL sat_level: got %0d want %0d", fifo_level, Depth); end
    hold_busy = 1'b0;
    wait_idle(1'b0, 3000, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL sat_timeout: busy %b want 0", busy); end
    bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad = i; break; end
    n_checks++;
    if (bad >= 0 || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL sat_bytes: %0d bytes, first diff at %0d, want %0d bytes",
                         got_q.size(), bad, exp_q.size());
    end
    n_checks++;
    if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", drop_count); end
    n_checks++;
    if (proto_err != 0) begin n_fail++; $display("FAIL protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_no_crlf();
    test_busy_hold();
    test_reset_midline();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_hex_reporter.md
Name: uart_hex_reporter

Overview:
- Upstream feeder for the UART transmitter (async_transmitter) in the measurement path.
- Captures measurement values (timer/latency counts) on a strobe and buffers them in a small FIFO.
- Serialises each value as uppercase ASCII hex, MSB nibble first, with optional CR LF.
- Drives the transmitter's start/data/busy handshake one character at a time.

Parameters:
- DATA_WIDTH, 32, measurement width; multiple of 4; DIGITS = DATA_WIDTH/4.
- FIFO_DEPTH, 4, value FIFO entries; power of 2, at least 2.
- SEND_CRLF, 1, 1 = append 0x0D 0x0A after the digits; 0 = digits only.

Ports:
- clk  in  1  system clock; same clock as the transmitter.
- rst_n  in  1  asynchronous active-low reset.
- meas_valid  in  1  one-cycle strobe; meas_value is valid in the same cycle.
- meas_value  in  DATA_WIDTH  measurement to report.
- tx_busy  in  1  transmitter busy, driven by TxD_busy.
- tx_start  out  1  one-cycle start pulse to TxD_start.
- tx_data  out  8  ASCII character to TxD_data.
- fifo_level  out  log2(FIFO_DEPTH)+1  current number of stored values.
- drop_count  out  8  saturating count of values dropped because the FIFO was full.
- busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.

Behaviour:
Interface and reset:
- One clock; reset is asynchronous and active-low.
- Reset values: tx_start=0, tx_data=0x00, fifo_level=0, drop_count=0, busy=0, FSM=IDLE, FIFO pointers=0.
- Reset asserted mid-line clears the FIFO and FSM immediately and drops tx_start at once.
- A character already latched by the transmitter completes on its own; no partial line resumes after reset.

FIFO:
- Push when meas_valid=1 and (level<FIFO_DEPTH, or a pop occurs in the same cycle).
- Otherwise the value is discarded and drop_count increments, saturating at 255.
- Pop only in the LOAD state.
- A push and pop in the same cycle leave the level unchanged.
- Pointers wrap modulo FIFO_DEPTH.

FSM states:
- IDLE: if FIFO not empty -> LOAD.
- LOAD (1 cycle): pop head into the shift register; char_idx=0 -> SEND.
- SEND: wait for tx_busy=0, then drive tx_start=1 for exactly one cycle with tx_data = current character -> WAIT_BUSY.
- WAIT_BUSY: wait for tx_busy=1; tx_data stays stable -> WAIT_DONE.
- WAIT_DONE: wait for tx_busy=0, then advance char_idx.
  - If the line is finished -> IDLE when the FIFO is empty, else LOAD.
  - Otherwise -> SEND.

Character generation:
- Characters 0..DIGITS-1 are nibbles from the MSB down.
- Nibble n maps to 0x30+n for n<=9 and 0x37+n for n>=10.
- When SEND_CRLF=1, character DIGITS is 0x0D and character DIGITS+1 is 0x0A.

Timing and protocol rules:
- Latency: strobe in cycle 0 with IDLE, empty FIFO and tx_busy=0 gives the push in cycle 0, LOAD in cycle 1, first tx_start in cycle 2.
- tx_start is never asserted while tx_busy=1.
- tx_start is never asserted in two consecutive cycles.
- The shift register is untouched by FIFO pushes during a line.

Test Plan:
1. Value 0x1234ABCD with a behavioural transmitter (busy 10 cycles per char) -> bytes 31 32 33 34 41 42 43 44 0D 0A, exactly 10 tx_start pulses, busy=0 afterwards.
2. Six strobes on consecutive cycles 0..5 while the transmitter is busy -> 5 values accepted (cycle-1 push coincides with the LOAD pop), drop_count=1; then 5 full lines in strobe order.
3. SEND_CRLF=0 with value 0x0000000F -> exactly 8 bytes "0000000F" (30×7, 46), then IDLE.
4. tx_busy forced high for 100 cycles before the first char -> tx_start stays 0 throughout; first pulse arrives 1 cycle after tx_busy falls.
5. rst_n low after 3 chars of line 1 with 2 values queued -> tx_start=0, fifo_level=0, drop_count=0 immediately; a new value 0xFFFFFFFF after release -> "FFFFFFFF\r\n".
6. 300 strobes while full -> drop_count saturates at 255 and never wraps.
